// File: rtl/mux16_rr_scheduler.sv
// 16-requester round-robin scheduler with bounded bursts.
// One owner at a time drives a 1-bit datapath through a 16:1 mux. The owner
// keeps the grant for up to BURST_LEN accepted transfers, or until it drops
// its request. On release, the next requester in ascending circular order
// after the owner takes over on the same edge, so there is no idle bubble.
module mux16_rr_scheduler #(
  parameter int BURST_LEN = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] req,
  input  logic [15:0] in,
  input  logic        ready,
  output logic [15:0] gnt,
  output logic [3:0]  sel,
  output logic        out,
  output logic        valid
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // Counter value at which an accepted transfer ends the burst.
  localparam logic [3:0] LAST_BEAT = 4'(BURST_LEN - 1);

  state_t      state_reg;
  logic [3:0]  sel_reg;
  logic [15:0] gnt_reg;
  logic [3:0]  cnt_reg;

  // Requests of the other 15 requesters, rotated so bit 0 is (sel+1) mod 16.
  // The owner itself is excluded so it always has the lowest priority.
  logic [14:0] rot_req;

  genvar gi;
  generate
    for (gi = 0; gi < 15; gi++) begin : g_rot
      assign rot_req[gi] = req[sel_reg + 4'(gi + 1)];
    end
  endgenerate

  logic       other_found;
  logic [3:0] other_win;
  logic       owner_req;
  logic       transfer;
  logic       release_now;

  // Circular priority search: first set bit starting just after the owner.
  always_comb begin
    other_found = 1'b0;
    other_win   = sel_reg;
    for (int k = 0; k < 15; k++) begin
      if (!other_found && rot_req[k]) begin
        other_found = 1'b1;
        other_win   = sel_reg + 4'(k + 1);
      end
    end
  end

  assign owner_req   = req[sel_reg];
  assign valid       = (|gnt_reg) && owner_req;
  assign transfer    = valid && ready;
  // Owner gives up the grant when it stops requesting or finishes its burst.
  assign release_now = !owner_req || (transfer && (cnt_reg == LAST_BEAT));

  assign gnt = gnt_reg;
  assign sel = sel_reg;
  assign out = in[sel_reg];

  // Grant state machine; all outputs except the mux and valid are registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      gnt_reg   <= 16'h0000;
      sel_reg   <= 4'hF;
      cnt_reg   <= 4'd0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (other_found) begin
            state_reg <= GRANT;
            sel_reg   <= other_win;
            gnt_reg   <= 16'd1 << other_win;
            cnt_reg   <= 4'd0;
          end else if (owner_req) begin
            // Only the last owner is asking: it is last in the circle.
            state_reg <= GRANT;
            gnt_reg   <= 16'd1 << sel_reg;
            cnt_reg   <= 4'd0;
          end
        end
        GRANT: begin
          if (release_now) begin
            if (other_found) begin
              sel_reg <= other_win;
              gnt_reg <= 16'd1 << other_win;
              cnt_reg <= 4'd0;
            end else if (owner_req) begin
              // Nobody else waiting: same owner starts a fresh burst.
              cnt_reg <= 4'd0;
            end else begin
              state_reg <= IDLE;
              gnt_reg   <= 16'h0000;
              cnt_reg   <= 4'd0;
            end
          end else if (transfer) begin
            cnt_reg <= cnt_reg + 4'd1;
          end
        end
        default: begin
          state_reg <= IDLE;
          gnt_reg   <= 16'h0000;
          cnt_reg   <= 4'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux16_rr_scheduler.sv
// Directed bench for mux16_rr_scheduler: a vector table for the basic
// grant/transfer/release behaviour, plus hand-written multi-cycle sequences
// for full rotation, ready stalls, idle re-grant, async reset and BURST_LEN=1.
module tb_mux16_rr_scheduler;

  logic        clk;
  logic        rst_n;
  logic [15:0] req;
  logic [15:0] din;
  logic        ready;
  logic [15:0] gnt;
  logic [3:0]  sel;
  logic        out;
  logic        valid;
  logic [15:0] gnt1;
  logic [3:0]  sel1;
  logic        out1;
  logic        valid1;

  int n_checks = 0;
  int n_fail   = 0;

  mux16_rr_scheduler #(.BURST_LEN(4)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .in(din), .ready(ready),
    .gnt(gnt), .sel(sel), .out(out), .valid(valid)
  );

  mux16_rr_scheduler #(.BURST_LEN(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .req(req), .in(din), .ready(ready),
    .gnt(gnt1), .sel(sel1), .out(out1), .valid(valid1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [15:0] req;
    logic [15:0] din;
    logic        rdy;
    logic [15:0] gnt;
    logic [3:0]  sel;
    logic        vld;
    logic        dout;
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = 16'h0000;
    din   = 16'h0000;
    ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_gnt", gnt, 16'h0000);
    chk("rst_sel", {12'h0, sel}, 16'h000F);
    chk("rst_valid", {15'h0, valid}, 16'h0000);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 16'h0000;
    din   = 16'h0000;
    ready = 1'b0;

    //                req       din       rdy   gnt       sel   vld   out
    vecs[0]  = '{16'h0001, 16'h0001, 1'b1, 16'h0001, 4'h0, 1'b1, 1'b1};
    vecs[1]  = '{16'h0001, 16'h0000, 1'b1, 16'h0001, 4'h0, 1'b1, 1'b0};
    vecs[2]  = '{16'h0001, 16'hFFFE, 1'b1, 16'h0001, 4'h0, 1'b1, 1'b0};
    vecs[3]  = '{16'h0001, 16'h0001, 1'b1, 16'h0001, 4'h0, 1'b1, 1'b1};
    vecs[4]  = '{16'h0001, 16'h0001, 1'b1, 16'h0001, 4'h0, 1'b1, 1'b1};
    vecs[5]  = '{16'h0002, 16'h0002, 1'b1, 16'h0002, 4'h1, 1'b1, 1'b1};
    vecs[6]  = '{16'h0000, 16'h0002, 1'b1, 16'h0000, 4'h1, 1'b0, 1'b1};
    vecs[7]  = '{16'h8001, 16'h8000, 1'b0, 16'h8000, 4'hF, 1'b1, 1'b1};
    vecs[8]  = '{16'h8001, 16'h0000, 1'b0, 16'h8000, 4'hF, 1'b1, 1'b0};
    vecs[9]  = '{16'h0003, 16'h0001, 1'b1, 16'h0001, 4'h0, 1'b1, 1'b1};
    vecs[10] = '{16'h0003, 16'h0000, 1'b1, 16'h0001, 4'h0, 1'b1, 1'b0};
    vecs[11] = '{16'h0003, 16'h0001, 1'b1, 16'h0001, 4'h0, 1'b1, 1'b1};
    vecs[12] = '{16'h0003, 16'h0001, 1'b1, 16'h0001, 4'h0, 1'b1, 1'b1};
    vecs[13] = '{16'h0003, 16'h0002, 1'b1, 16'h0002, 4'h1, 1'b1, 1'b1};
    vecs[14] = '{16'h0001, 16'h0002, 1'b1, 16'h0001, 4'h0, 1'b1, 1'b0};

    // Table: basic grant, burst renew, release on drop, idle, wrap-around.
    do_reset();
    for (int i = 0; i < 15; i++) begin
      req   = vecs[i].req;
      din   = vecs[i].din;
      ready = vecs[i].rdy;
      tick();
      $display("vec %0d req=%h in=%h rdy=%0d -> gnt=%h sel=%0d valid=%0d out=%0d",
               i, req, din, ready, gnt, sel, valid, out);
      chk($sformatf("vec%0d_gnt", i), gnt, vecs[i].gnt);
      chk($sformatf("vec%0d_sel", i), {12'h0, sel}, {12'h0, vecs[i].sel});
      chk($sformatf("vec%0d_valid", i), {15'h0, valid}, {15'h0, vecs[i].vld});
      chk($sformatf("vec%0d_out", i), {15'h0, out}, {15'h0, vecs[i].dout});
    end

    // Full rotation: all requesting, 4 transfers each, no idle cycles.
    do_reset();
    req   = 16'hFFFF;
    din   = 16'h5A5A;
    ready = 1'b1;
    for (int t = 0; t < 68; t++) begin
      logic [3:0] exp_sel;
      tick();
      exp_sel = 4'((t / 4) % 16);
      $display("rot t=%0d gnt=%h sel=%0d valid=%0d", t, gnt, sel, valid);
      chk($sformatf("rot%0d_gnt", t), gnt, 16'd1 << exp_sel);
      chk($sformatf("rot%0d_valid", t), {15'h0, valid}, 16'h0001);
    end

    // Ready stall on owner 5 freezes the counter; burst resumes after.
    do_reset();
    req   = 16'h0020;
    ready = 1'b1;
    tick();
    chk("stall_grant", gnt, 16'h0020);
    tick();
    req   = 16'h0021;
    ready = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      $display("stall c=%0d gnt=%h sel=%0d", c, gnt, sel);
      chk($sformatf("stall%0d_gnt", c), gnt, 16'h0020);
      chk($sformatf("stall%0d_sel", c), {12'h0, sel}, 16'h0005);
    end
    ready = 1'b1;
    tick();
    chk("resume1_gnt", gnt, 16'h0020);
    tick();
    chk("resume2_gnt", gnt, 16'h0020);
    tick();
    $display("resume3 gnt=%h sel=%0d", gnt, sel);
    chk("resume3_gnt", gnt, 16'h0001);
    chk("resume3_sel", {12'h0, sel}, 16'h0000);

    // Owner 3 drops its request mid-burst: idle keeps sel, later re-grant.
    do_reset();
    req   = 16'h0008;
    ready = 1'b1;
    tick();
    chk("drop_grant", gnt, 16'h0008);
    tick();
    tick();
    req = 16'h0000;
    tick();
    $display("drop idle gnt=%h sel=%0d valid=%0d", gnt, sel, valid);
    chk("drop_idle_gnt", gnt, 16'h0000);
    chk("drop_idle_sel", {12'h0, sel}, 16'h0003);
    chk("drop_idle_valid", {15'h0, valid}, 16'h0000);
    tick();
    chk("drop_idle2_gnt", gnt, 16'h0000);
    req = 16'h0008;
    tick();
    $display("drop regrant gnt=%h sel=%0d", gnt, sel);
    chk("regrant_gnt", gnt, 16'h0008);
    chk("regrant_sel", {12'h0, sel}, 16'h0003);

    // Asynchronous reset mid-burst (owner 7, counter 2).
    do_reset();
    req   = 16'h0080;
    ready = 1'b1;
    tick();
    chk("areset_grant", gnt, 16'h0080);
    tick();
    tick();
    #3;
    rst_n = 1'b0;
    #1;
    $display("async reset gnt=%h sel=%0d valid=%0d", gnt, sel, valid);
    chk("areset_gnt", gnt, 16'h0000);
    chk("areset_sel", {12'h0, sel}, 16'h000F);
    chk("areset_valid", {15'h0, valid}, 16'h0000);
    req = 16'hFFFF;
    tick();
    chk("areset_hold_gnt", gnt, 16'h0000);
    rst_n = 1'b1;
    #1;
    chk("areset_release_gnt", gnt, 16'h0000);
    tick();
    $display("after reset gnt=%h sel=%0d", gnt, sel);
    chk("first_grant_gnt", gnt, 16'h0001);
    chk("first_grant_sel", {12'h0, sel}, 16'h0000);

    // BURST_LEN=1 rotates after every transfer; BURST_LEN=4 does not.
    do_reset();
    req   = 16'h0003;
    din   = 16'h0002;
    ready = 1'b1;
    tick();
    chk("bl1_t0_gnt", gnt1, 16'h0001);
    chk("bl1_t0_out", {15'h0, out1}, 16'h0000);
    tick();
    $display("bl1 t1 gnt1=%h gnt=%h", gnt1, gnt);
    chk("bl1_t1_gnt", gnt1, 16'h0002);
    chk("bl1_t1_valid", {15'h0, valid1}, 16'h0001);
    chk("bl1_t1_out", {15'h0, out1}, 16'h0001);
    chk("bl4_t1_gnt", gnt, 16'h0001);
    tick();
    chk("bl1_t2_gnt", gnt1, 16'h0001);
    chk("bl1_t2_sel", {12'h0, sel1}, 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mux16_rr_scheduler.md
MUX16_RR_SCHEDULER -- requirements
Module: mux16_rr_scheduler

Interface
REQ-001 Parameter BURST_LEN, default 4, legal 1..16: maximum transfers per grant before the grant rotates.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 req  input  16  per-requester request level; bit i = requester i.
REQ-005 in  input  16  per-requester data bit; bit i = requester i's data.
REQ-006 ready  input  1  consumer accepts out this cycle.
REQ-007 gnt  output  16  one-hot grant, registered; all-zero when no owner.
REQ-008 sel  output  4  registered index of current/last owner; drives the 16:1 mux select.
REQ-009 out  output  1  in[sel], combinational through a 16:1 mux.
REQ-010 valid  output  1  high when gnt != 0 and req[sel] == 1.

Function
REQ-011 The block SHALL implement two states, IDLE (gnt == 0) and GRANT (gnt == one-hot of sel).
REQ-012 A transfer SHALL occur on a cycle where valid && ready; out on that cycle is the transferred bit.
REQ-013 A 4-bit burst counter SHALL increment on each transfer and clear to 0 on every new grant.
REQ-014 Round-robin search SHALL start at index (sel+1) mod 16, ascend with wrap past 15 to 0, and take the first set req bit; the current owner has lowest priority.
REQ-015 IDLE, req == 0: SHALL stay in IDLE; sel holds its value.
REQ-016 IDLE, req != 0: on the next edge SHALL load sel with the search winner, set gnt to its one-hot, and enter GRANT; latency req->gnt = 1 cycle.
REQ-017 GRANT, req[sel] == 1, no transfer (ready low): SHALL hold sel, gnt and counter unchanged.
REQ-018 GRANT, transfer with counter < BURST_LEN-1: SHALL keep the grant and increment the counter.
REQ-019 Release events: (a) req[sel] == 0 (no transfer counted); (b) transfer with counter == BURST_LEN-1.
REQ-020 On release, if the search (REQ-014) finds any set req bit among the other 15 requesters, the block SHALL grant the winner at the same edge with no IDLE bubble.
REQ-021 On release, if no other requester is set, the block SHALL continue the current owner with a new burst when req[sel] == 1; otherwise it SHALL enter IDLE, keeping sel.
REQ-022 A transfer SHALL be counted at most once per cycle; simultaneous release and new requests are resolved solely by REQ-020/021.
REQ-023 gnt SHALL never have more than one bit set, and SHALL never be nonzero in IDLE.
REQ-024 BURST_LEN == 1 SHALL rotate the grant after every transfer.

Reset
REQ-025 rst_n low SHALL immediately force state IDLE, gnt = 16'h0000, sel = 4'hF, counter = 0, valid = 0, independent of clk.
REQ-026 With sel = 4'hF after reset, the first search SHALL start at index 0.
REQ-027 Reset asserted mid-burst SHALL abandon the burst; no grant SHALL survive reset.
REQ-028 After rst_n deasserts, the first grant SHALL occur no earlier than the first rising edge with rst_n high.

Verification
REQ-029 Reset, then req = 16'h0001, ready = 1 -> gnt = 16'h0001 after 1 edge, sel = 0, out follows in[0], valid = 1.
REQ-030 req = 16'hFFFF, ready = 1, BURST_LEN = 4 -> owners 0,1,2,...,15,0 in order, each for exactly 4 transfers, no idle cycles between them.
REQ-031 Owner 15 releases with req = 16'h0003 -> next grant is index 0 (wrap-around), then 1.
REQ-032 Owner 5 active, ready held low for 10 cycles -> gnt and sel unchanged, counter frozen; the burst resumes when ready rises.
REQ-033 Owner 3 drops req[3] after 2 transfers, with req = 16'h0000 otherwise -> IDLE on next edge, gnt = 0, sel = 3; a later req = 16'h0008 re-grants 3.
REQ-034 rst_n pulsed low mid-burst (owner 7, counter 2) -> gnt = 0 and sel = 4'hF immediately without a clock edge; after release with req = 16'hFFFF, the first grant is index 0.
